// File: rtl/fetch_stage_pkg.sv
// Shared fetch-stage constants: widths, the NOP bubble encoding and the default boot address.
package fetch_stage_pkg;

    localparam int INSTR_W = 32;
    localparam int PC_W    = 32;

    // addi x0,x0,0
    localparam logic [INSTR_W-1:0] NOP_INSTR        = 32'h0000_0013;
    localparam logic [PC_W-1:0]    RESET_PC_DEFAULT = 32'h4000_0000;

    function automatic logic [PC_W-1:0] word_align(input logic [PC_W-1:0] addr);
        return {addr[PC_W-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/fetch_stage_skid_buf.sv
// Skid register that parks a fetched word while decode is stalled, so nothing is lost.
module fetch_skid_buf
    import fetch_stage_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               capture,
    input  logic               keep,
    input  logic               clear,
    input  logic [INSTR_W-1:0] cap_instr,
    input  logic [PC_W-1:0]    cap_pc,
    output logic               valid,
    output logic [INSTR_W-1:0] instr,
    output logic [PC_W-1:0]    pc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            instr <= NOP_INSTR;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
        end else if (capture) begin
            valid <= 1'b1;
            instr <= cap_instr;
            pc    <= cap_pc;
        end else if (!keep) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/fetch_stage.sv
// Instruction-fetch stage: PC sequencing, 1-cycle imem handshake, stall skid and redirect squash.
// Optional per-cycle statistics counters are built when FETCH_STATS_EN is defined.
module fetch_stage
    import fetch_stage_pkg::*;
#(
    parameter logic [PC_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               stall,
    input  logic               redirect_valid,
    input  logic [PC_W-1:0]    redirect_pc,
    output logic               imem_en,
    output logic [PC_W-1:0]    imem_addr,
    input  logic [INSTR_W-1:0] imem_rdata,
    output logic [INSTR_W-1:0] if_instr,
    output logic [PC_W-1:0]    if_pc,
    output logic               if_valid
`ifdef FETCH_STATS_EN
    ,
    output logic [31:0]        stat_fetched,
    output logic [31:0]        stat_bubbles
`endif
);

    logic [PC_W-1:0]    pc_next;
    logic               req_valid;
    logic [PC_W-1:0]    req_pc;
    logic               hold_valid;
    logic [INSTR_W-1:0] hold_instr;
    logic [PC_W-1:0]    hold_pc;

    logic               issue;
    logic [PC_W-1:0]    issue_addr;
    logic               cand_valid;
    logic [INSTR_W-1:0] cand_instr;
    logic [PC_W-1:0]    cand_pc;
    logic               skid_capture;
    logic               skid_keep;
    logic               skid_clear;

    // A redirect always issues, even under stall.
    assign issue      = redirect_valid | ~stall;
    assign issue_addr = redirect_valid ? word_align(redirect_pc) : pc_next;

    // Gate with rst_n so no request leaks out while reset is held.
    assign imem_en   = rst_n & issue;
    assign imem_addr = issue_addr;

    assign cand_valid = hold_valid | req_valid;
    assign cand_instr = hold_valid ? hold_instr : imem_rdata;
    assign cand_pc    = hold_valid ? hold_pc    : req_pc;

    assign if_valid = cand_valid & ~redirect_valid;
    assign if_instr = if_valid ? cand_instr : NOP_INSTR;
    assign if_pc    = if_valid ? cand_pc    : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_next   <= RESET_PC;
            req_valid <= 1'b0;
            req_pc    <= '0;
        end else if (issue) begin
            req_valid <= 1'b1;
            req_pc    <= issue_addr;
            pc_next   <= issue_addr + 32'd4;
        end else begin
            req_valid <= 1'b0;
        end
    end

    assign skid_clear   = issue;
    assign skid_capture = ~issue & req_valid;
    assign skid_keep    = ~issue & hold_valid;

    fetch_skid_buf u_skid (
        .clk       (clk),
        .rst_n     (rst_n),
        .capture   (skid_capture),
        .keep      (skid_keep),
        .clear     (skid_clear),
        .cap_instr (imem_rdata),
        .cap_pc    (req_pc),
        .valid     (hold_valid),
        .instr     (hold_instr),
        .pc        (hold_pc)
    );

    // An outstanding request and a parked word must never coexist.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            assert (!(req_valid && hold_valid));
        end
    end

`ifdef FETCH_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_fetched <= '0;
            stat_bubbles <= '0;
        end else begin
            if (if_valid && !stall) begin
                stat_fetched <= stat_fetched + 32'd1;
            end
            if (!if_valid) begin
                stat_bubbles <= stat_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed plus random bench for fetch_stage against a pending-word reference model.
module tb_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        stall;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_en;
    logic [31:0] imem_addr;
    logic [31:0] imem_rdata = 32'h0;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic        if_valid;
`ifdef FETCH_STATS_EN
    logic [31:0] stat_fetched;
    logic [31:0] stat_bubbles;
`endif

    int total = 0;
    int bad   = 0;

    // Model: at most one fetched-but-unconsumed word, plus the next sequential address.
    logic        m_pend_v;
    logic [31:0] m_pend_pc;
    logic [31:0] m_next;
    logic [31:0] m_fetched;
    logic [31:0] m_bubbles;

    localparam logic [31:0] NOP = 32'h0000_0013;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_en        (imem_en),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .if_instr       (if_instr),
        .if_pc          (if_pc),
        .if_valid       (if_valid)
`ifdef FETCH_STATS_EN
        ,
        .stat_fetched   (stat_fetched),
        .stat_bubbles   (stat_bubbles)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h4000_0008) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
    endfunction

    // Synchronous memory; the bus carries garbage after a cycle with no request.
    always @(posedge clk) begin
        imem_rdata <= imem_en ? mem_word(imem_addr) : $urandom;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pend_v  = 1'b0;
        m_pend_pc = 32'h0;
        m_next    = 32'h4000_0000;
        m_fetched = 32'h0;
        m_bubbles = 32'h0;
    endtask

    task automatic check_stats();
`ifdef FETCH_STATS_EN
        chk("stat_fetched", stat_fetched, m_fetched);
        chk("stat_bubbles", stat_bubbles, m_bubbles);
`endif
    endtask

    // Called at negedge: drive, check, advance one clock, return at next negedge.
    task automatic step(input logic s, input logic r, input logic [31:0] rp);
        logic        e_valid;
        logic        e_en;
        logic [31:0] e_addr;
        logic [31:0] tgt;
        stall          = s;
        redirect_valid = r;
        redirect_pc    = rp;
        tgt     = rp & 32'hFFFF_FFFC;
        e_valid = m_pend_v & ~r;
        e_en    = r | ~s;
        e_addr  = r ? tgt : m_next;
        #1;
        check_stats();
        chk("if_valid", {31'h0, if_valid}, {31'h0, e_valid});
        chk("if_instr", if_instr, e_valid ? mem_word(m_pend_pc) : NOP);
        chk("if_pc", if_pc, e_valid ? m_pend_pc : 32'h0);
        chk("imem_en", {31'h0, imem_en}, {31'h0, e_en});
        if (e_en) chk("imem_addr", imem_addr, e_addr);
        $display("step stall=%0d redir=%0d rpc=%h en=%0d addr=%h valid=%0d pc=%h instr=%h",
                 s, r, rp, imem_en, imem_addr, if_valid, if_pc, if_instr);
        @(posedge clk);
        if (e_valid && !s) m_fetched = m_fetched + 1;
        if (!e_valid)      m_bubbles = m_bubbles + 1;
        if (r) begin
            m_pend_v  = 1'b1;
            m_pend_pc = tgt;
            m_next    = tgt + 32'd4;
        end else if (!s) begin
            m_pend_v  = 1'b1;
            m_pend_pc = m_next;
            m_next    = m_next + 32'd4;
        end
        @(negedge clk);
    endtask

    task automatic reset_checks(input string tag);
        #1;
        chk({tag, "_en"}, {31'h0, imem_en}, 32'h0);
        chk({tag, "_valid"}, {31'h0, if_valid}, 32'h0);
        chk({tag, "_instr"}, if_instr, NOP);
        chk({tag, "_pc"}, if_pc, 32'h0);
        check_stats();
        $display("reset %s en=%0d valid=%0d instr=%h pc=%h", tag, imem_en, if_valid, if_instr, if_pc);
    endtask

    initial begin
        rst_n          = 1'b0;
        stall          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'h0;
        model_reset();
        @(negedge clk);
        @(negedge clk);
        reset_checks("por");
        rst_n = 1'b1;

        // Sequential fetch from RESET_PC, then stall with DEADBEEF in flight.
        repeat (3) step(1'b0, 1'b0, 32'h0);
        repeat (3) step(1'b1, 1'b0, 32'h0);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        // Redirect with a word in flight, misaligned target.
        step(1'b0, 1'b1, 32'h4000_0102);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        // Redirect together with stall while a word is parked.
        repeat (2) step(1'b1, 1'b0, 32'h0);
        step(1'b1, 1'b1, 32'h4000_0200);
        repeat (2) step(1'b0, 1'b0, 32'h0);
        // Asynchronous reset in the middle of a stall.
        step(1'b1, 1'b0, 32'h0);
        stall = 1'b1;
        rst_n = 1'b0;
        model_reset();
        reset_checks("mid_stall");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) step(1'b0, 1'b0, 32'h0);
        // Address wrap at the top of the space.
        step(1'b0, 1'b1, 32'hFFFF_FFFC);
        repeat (3) step(1'b0, 1'b0, 32'h0);
        // Back-to-back redirects.
        step(1'b0, 1'b1, 32'h1000_0000);
        step(1'b0, 1'b1, 32'h2000_0004);
        repeat (2) step(1'b0, 1'b0, 32'h0);

        for (int i = 0; i < 2000; i++) begin
            logic        s;
            logic        r;
            logic [31:0] rp;
            s  = ($urandom_range(0, 9) < 3);
            r  = ($urandom_range(0, 9) == 0);
            rp = ($urandom_range(0, 7) == 0) ? (32'hFFFF_FFF0 | ($urandom & 32'hF)) : $urandom;
            step(s, r, rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
